// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding for the bit-serial adder controller
package serial_adder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// serial_adder_ctrl_fa: combinational 1-bit full-adder cell
module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one bit per clock LSB first, valid/ready in and out
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_e state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, in_ready_q, busy_q, out_valid_q, fa_s, fa_co;

    serial_adder_ctrl_fa u_fa (
        .a   (sh_a_q[0]),
        .b   (sh_b_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .cout(fa_co)
    );

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                sh_a_d  = op_a;
                sh_b_d  = op_b;
                carry_d = cin;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // new sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= state_d == ST_IDLE;
            busy_q      <= state_d == ST_RUN;
            out_valid_q <= state_d == ST_DONE;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench against an arithmetic reference model
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;

    logic iv1 = 1'b0, or1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic ir1, ov1, s1, co1, bz1;

    int checks = 0;
    int passed = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .op_a(a1), .op_b(b1), .cin(c1), .out_valid(ov1),
        .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
    );

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int stall, input bit noise,
                          output logic [W-1:0] s, output logic co, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        else passed++;
        op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (noise) begin
                in_valid = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        s = sum; co = cout;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sum !== s || cout !== co)
                $display("FAIL hold: out_valid=%b sum=%h cout=%b required 1 %h %b", out_valid, sum, cout, s, co);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input int stall, input bit noise);
        logic [W-1:0] s;
        logic co;
        int lat;
        logic [W:0] exp;
        exp = {1'b0, a} + {1'b0, b} + (W + 1)'(c);
        run_op(a, b, c, stall, noise, s, co, lat);
        checks++;
        if ({co, s} !== exp || lat != W)
            $display("FAIL %s: %h+%h+%b got cout=%b sum=%h lat=%0d required cout=%b sum=%h lat=%0d",
                     name, a, b, c, co, s, lat, exp[W], exp[W-1:0], W);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset: sum=%h cout=%b out_valid=%b busy=%b required 00 0 0 0", sum, cout, out_valid, busy);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        else passed++;
    endtask

    task automatic test_directed();
        check_op("zero", 8'h00, 8'h00, 1'b0, 0, 1'b0);
        check_op("ripple", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        check_op("stall", 8'hA5, 8'h5A, 1'b1, 5, 1'b0);
        check_op("max", 8'hFF, 8'hFF, 1'b1, 1, 1'b0);
    endtask

    task automatic test_busy();
        int cnt;
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (busy === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != W || out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL busy: busy_cycles=%0d out_valid=%b in_ready=%b required %0d 1 0", cnt, out_valid, in_ready, W);
        else passed++;
        checks++;
        if (sum !== 8'h46 || cout !== 1'b0)
            $display("FAIL busy_sum: sum=%h cout=%b required 46 0", sum, cout);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        bit seen;
        op_a = 8'h3C; op_b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        rst_n = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
            $display("FAIL abort: busy=%b out_valid=%b sum=%h cout=%b required 0 0 00 0", busy, out_valid, sum, cout);
        else passed++;
        rst_n = 1'b1; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1)
            $display("FAIL abort_idle: out_valid_seen=%b in_ready=%b required 0 1", seen, in_ready);
        else passed++;
        check_op("after_abort", 8'h3C, 8'h0F, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            check_op("random", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    endtask

    task automatic test_width1();
        int lat;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; c1 = i[0];
            exp = 2'(a1) + 2'(b1) + 2'(c1);
            iv1 = 1'b1; or1 = 1'b0;
            @(posedge clk); #1;
            iv1 = 1'b0;
            lat = 0;
            while (ov1 !== 1'b1 && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            checks++;
            if ({co1, s1} !== exp || lat != 1)
                $display("FAIL width1: a=%b b=%b cin=%b got cout=%b sum=%b lat=%0d required %b %b 1",
                         a1, b1, c1, co1, s1, lat, exp[1], exp[0]);
            else passed++;
            or1 = 1'b1;
            @(posedge clk); #1;
            or1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_abort();
        test_random();
        test_width1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
